// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: valid/ready byte intake into a small FIFO,
// serialised LSB-first on UART_TX with zero-gap back-to-back frames.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   data_in,
  input  logic                         data_valid,
  output logic                         data_ready,
  output logic                         UART_TX,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int CLKS_PER_BIT = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int CNT_W        = PTR_W + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx_fifo: CLKS_PER_BIT must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two and at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state, state_nx;
  logic [BAUD_W-1:0]  baud_cnt, baud_nx;
  logic [2:0]         bit_idx, bit_nx;
  logic [7:0]         shift, shift_nx;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [CNT_W-1:0]   count_nx;
  logic               push, pop;
  logic               tx_nx, busy_nx;

  // Ready comes from the registered count only, so a full FIFO refuses a
  // push even on the edge that pops.
  assign data_ready = !rst && (fifo_count < CNT_FULL);
  assign push       = data_valid && data_ready;
  assign count_nx   = fifo_count + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      UART_TX    <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      baud_cnt   <= baud_nx;
      bit_idx    <= bit_nx;
      fifo_count <= count_nx;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      UART_TX    <= tx_nx;
      busy       <= busy_nx;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_nx;
    if (push) mem[wr_ptr] <= data_in;
  end

  always_comb begin
    state_nx = state;
    baud_nx  = baud_cnt;
    bit_nx   = bit_idx;
    shift_nx = shift;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          pop      = 1'b1;
          shift_nx = mem[rd_ptr];
          baud_nx  = '0;
          state_nx = START;
        end
      end
      START: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_nx  = '0;
          bit_nx   = '0;
          state_nx = DATA;
        end else begin
          baud_nx = baud_cnt + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_nx  = '0;
          shift_nx = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) state_nx = STOP;
          else                 bit_nx   = bit_idx + 3'd1;
        end else begin
          baud_nx = baud_cnt + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_nx = '0;
          // Chain straight into the next start bit to keep frames gap-free.
          if (fifo_count != '0) begin
            pop      = 1'b1;
            shift_nx = mem[rd_ptr];
            state_nx = START;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          baud_nx = baud_cnt + BAUD_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Line level and busy are derived from the next state and registered.
  always_comb begin
    tx_nx = 1'b1;
    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shift_nx[0];
      default: tx_nx = 1'b1;
    endcase
    busy_nx = (state_nx != IDLE) || (count_nx != '0);
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed timing checks plus a decoding line monitor
// fed by a queue of bytes the driver saw accepted.
module tb_uart_tx_fifo;

  localparam int CLK_FREQ   = 1000000;
  localparam int BAUD       = 100000;
  localparam int FIFO_DEPTH = 4;
  localparam int CPB        = 10;
  localparam int FRAME      = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       UART_TX;
  logic       busy;
  logic [2:0] fifo_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b1;

  logic [7:0] expq[$];
  int         starts[$];

  uart_tx_fifo #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .UART_TX    (UART_TX),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Presents b from the next falling edge and holds valid until accepted;
  // with churn, data_in takes a fresh random value every stalled cycle.
  task automatic send(input logic [7:0] b, input bit score, input bit churn, output int edge_no);
    bit acc;
    int guard;
    @(negedge clk);
    data_in    = b;
    data_valid = 1'b1;
    guard      = 0;
    forever begin
      #1;
      acc = data_ready;
      @(posedge clk);
      if (acc) break;
      guard++;
      if (guard > 3000) begin
        chk("send_timeout", 32'd0, 32'd1);
        break;
      end
      @(negedge clk);
      if (churn) data_in = 8'($urandom);
    end
    edge_no = cyc;
    if (score) expq.push_back(data_in);
  endtask

  // Line monitor: on a falling edge captures one full frame sample-by-sample.
  initial begin : monitor
    logic        prev;
    logic [99:0] s;
    logic [9:0]  bits;
    int          shape_bad;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && prev === 1'b1 && UART_TX === 1'b0) begin
        starts.push_back(cyc - 1);
        s[0] = UART_TX;
        for (int i = 1; i < FRAME; i++) begin
          @(negedge clk);
          s[i] = UART_TX;
        end
        shape_bad = 0;
        for (int b = 0; b < 10; b++) begin
          bits[b] = s[b*CPB];
          for (int j = 1; j < CPB; j++)
            if (s[b*CPB+j] !== bits[b]) shape_bad++;
        end
        if (bits[0] !== 1'b0) shape_bad++;
        if (bits[9] !== 1'b1) shape_bad++;
        chk("frame_shape", shape_bad, 0);
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: got %0h want none", bits[8:1]);
        end else begin
          chk("rx_byte", bits[8:1], expq.pop_front());
        end
      end
      prev = UART_TX;
    end
  end

  initial begin : stim
    int e0, e, k, fall, bad_tx, falls;
    logic [7:0] burst [6];
    logic exp_tx, tx_at1, prev_tx;
    burst = '{8'h00, 8'hFF, 8'hA5, 8'h3C, 8'h81, 8'h7E};

    // Reset held with a pending producer: nothing may be accepted.
    rst = 1'b1; data_valid = 1'b1; data_in = 8'hAA;
    repeat (3) begin
      @(negedge clk);
      chk("rst_tx", UART_TX, 1);
      chk("rst_busy", busy, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_ready", data_ready, 0);
    end
    rst = 1'b0; data_valid = 1'b0;
    @(negedge clk);
    chk("rel_ready", data_ready, 1);
    chk("rel_count", fifo_count, 0);
    chk("rel_busy", busy, 0);
    repeat (5) @(negedge clk);

    // Single byte: exact waveform and busy fall edge.
    send(8'h55, 1'b1, 1'b0, e0);
    fall = -1; bad_tx = 0; tx_at1 = 1'b1;
    for (k = 0; k <= 101; k++) begin
      @(negedge clk);
      if (k == 0) data_valid = 1'b0;
      if (k >= 1 && k <= 10)       exp_tx = 1'b0;
      else if (k >= 11 && k <= 90) exp_tx = 8'h55 >> ((k - 11) / 10);
      else                         exp_tx = 1'b1;
      if (UART_TX !== exp_tx) bad_tx++;
      if (k == 1) tx_at1 = UART_TX;
      if (k >= 1 && busy === 1'b0 && fall < 0) fall = k;
    end
    chk("t2_latency", tx_at1, 0);
    chk("t2_wave", bad_tx, 0);
    chk("t2_busy_fall", fall, 101);
    repeat (5) @(negedge clk);

    // Burst of six with valid held: fills, stalls, resumes after first STOP pop.
    starts.delete();
    send(burst[0], 1'b1, 1'b0, e0);
    for (int i = 1; i < 5; i++) begin
      send(burst[i], 1'b1, 1'b0, e);
      chk("t3_consec", e - e0, i);
    end
    @(negedge clk);
    chk("t3_full_count", fifo_count, 4);
    chk("t3_full_ready", data_ready, 0);
    send(burst[5], 1'b1, 1'b0, e);
    chk("t3_sixth_edge", e - e0, 102);
    @(negedge clk);
    data_valid = 1'b0;
    fall = -1;
    for (int i = 0; i < 2000 && fall < 0; i++) begin
      if (busy === 1'b0) fall = cyc - 1;
      else @(negedge clk);
    end
    chk("t3_frames", starts.size(), 6);
    if (starts.size() == 6) begin
      chk("t3_first_start", starts[0] - e0, 1);
      bad_tx = 0;
      for (int i = 1; i < 6; i++) if (starts[i] - starts[i-1] != FRAME) bad_tx++;
      chk("t3_contiguous", bad_tx, 0);
      chk("t3_total_len", fall - starts[0], 600);
    end
    repeat (5) @(negedge clk);

    // Reset during DATA bit 3 of the first of two frames.
    mon_en = 1'b0;
    send(8'hC3, 1'b0, 1'b0, e0);
    send(8'h12, 1'b0, 1'b0, e);
    @(negedge clk);
    data_valid = 1'b0;
    while (cyc - 1 < e0 + 45) @(negedge clk);
    chk("t4_pre_tx", UART_TX, 0);
    chk("t4_pre_count", fifo_count, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t4_tx", UART_TX, 1);
    chk("t4_count", fifo_count, 0);
    chk("t4_busy", busy, 0);
    rst = 1'b0;
    falls = 0; prev_tx = UART_TX; bad_tx = 0;
    repeat (300) begin
      @(negedge clk);
      if (prev_tx === 1'b1 && UART_TX === 1'b0) falls++;
      if (busy !== 1'b0 || fifo_count !== 3'd0) bad_tx++;
      prev_tx = UART_TX;
    end
    chk("t4_no_fall", falls, 0);
    chk("t4_quiet", bad_tx, 0);
    mon_en = 1'b1;

    // Stall integrity: back-to-back with data_in churning while refused.
    for (int i = 0; i < 12; i++) send(8'($urandom), 1'b1, 1'b1, e);
    @(negedge clk);
    data_valid = 1'b0;

    // 256 incrementing bytes with random producer gaps.
    for (int i = 0; i < 256; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        data_valid = 1'b0;
      end
      send(8'(i), 1'b1, 1'b0, e);
    end
    @(negedge clk);
    data_valid = 1'b0;

    for (int i = 0; i < 40000 && (expq.size() != 0 || busy !== 1'b0); i++) @(negedge clk);
    chk("drain", (expq.size() == 0) && (busy === 1'b0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
